// File: rtl/spi_slave_pkg.sv
// Shared constants for the SPI slave receive path: field widths, status bit
// positions and the deframer state encoding.
package spi_slave_pkg;

  localparam int STATUS_W = 4;
  localparam int ADDR_W   = 20;
  localparam int DATA_W   = 16;
  localparam int HDR_BITS = STATUS_W + ADDR_W;

  localparam int ST_WR    = 2;
  localparam int ST_BURST = 1;
  localparam int ST_SEL   = 0;

  localparam int CNT_W = 5;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HDR  = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for one asynchronous input, with rise/fall detect
// taken against one extra flop behind the synchronised level.
module spi_sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] chain_q, chain_d;
  logic              prev_q, prev_d;

  always_comb begin
    chain_d = {chain_q[STAGES-2:0], din};
    prev_d  = chain_q[STAGES-1];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      chain_q <= {STAGES{RESET_VAL}};
      prev_q  <= RESET_VAL;
    end else begin
      chain_q <= chain_d;
      prev_q  <= prev_d;
    end
  end

  assign sync_o = chain_q[STAGES-1];
  assign rise_o = sync_o & ~prev_q;
  assign fall_o = ~sync_o & prev_q;

endmodule

// File: rtl/spi_rx_deframer.sv
// SPI mode-0 slave receive front end: splits each frame into a status/address
// header and a stream of data words, each announced by a one-cycle strobe.
module spi_rx_deframer #(
  parameter int SYNC_STAGES = 2,
  parameter int STATUS_W    = spi_slave_pkg::STATUS_W,
  parameter int ADDR_W      = spi_slave_pkg::ADDR_W,
  parameter int DATA_W      = spi_slave_pkg::DATA_W
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                sclk,
  input  logic                mosi,
  input  logic                cs_n,
  output logic [STATUS_W-1:0] status,
  output logic [ADDR_W-1:0]   addr,
  output logic [DATA_W-1:0]   wdata,
  output logic                status_ready,
  output logic                address_ready,
  output logic                data_ready,
  output logic                cs_n_o,
  output logic                frame_err
);
  import spi_slave_pkg::*;

  localparam int               HDR_N    = STATUS_W + ADDR_W;
  localparam logic [CNT_W-1:0] HDR_CNT  = CNT_W'(HDR_N);
  localparam logic [CNT_W-1:0] DATA_CNT = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic sclk_rise, mosi_sync, cs_sync;
  logic unused_sclk_sync, unused_sclk_fall;
  logic unused_mosi_rise, unused_mosi_fall;
  logic unused_cs_rise, unused_cs_fall;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .reset_n(reset_n), .din(sclk),
    .sync_o(unused_sclk_sync), .rise_o(sclk_rise), .fall_o(unused_sclk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .reset_n(reset_n), .din(mosi),
    .sync_o(mosi_sync), .rise_o(unused_mosi_rise), .fall_o(unused_mosi_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .clk(clk), .reset_n(reset_n), .din(cs_n),
    .sync_o(cs_sync), .rise_o(unused_cs_rise), .fall_o(unused_cs_fall)
  );

  logic [1:0]          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [HDR_N-1:0]    sr_q, sr_d;
  logic [STATUS_W-1:0] status_q, status_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                status_ready_q, status_ready_d;
  logic                data_ready_q, data_ready_d;
  logic                frame_err_q, frame_err_d;
  logic [CNT_W-1:0]    target;

  // A full field is unloaded one cycle after its last bit is shifted in; that
  // unload wins over a cs_n rise so a frame ending exactly on a boundary is clean.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    sr_d           = sr_q;
    status_d       = status_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    status_ready_d = 1'b0;
    data_ready_d   = 1'b0;
    frame_err_d    = 1'b0;
    target         = (state_q == S_HDR) ? HDR_CNT : DATA_CNT;

    case (state_q)
      S_IDLE: begin
        if (!cs_sync) begin
          state_d = S_HDR;
          cnt_d   = '0;
          sr_d    = '0;
        end
      end
      S_HDR, S_DATA: begin
        if (cnt_q == target) begin
          cnt_d = '0;
          if (state_q == S_HDR) begin
            status_d       = sr_q[HDR_N-1 -: STATUS_W];
            addr_d         = sr_q[ADDR_W-1:0];
            status_ready_d = 1'b1;
          end else begin
            wdata_d      = sr_q[DATA_W-1:0];
            data_ready_d = 1'b1;
          end
          state_d = cs_sync ? S_IDLE : S_DATA;
        end else if (sclk_rise && (!cs_sync || (cnt_q + CNT_ONE) == target)) begin
          sr_d  = {sr_q[HDR_N-2:0], mosi_sync};
          cnt_d = cnt_q + CNT_ONE;
        end else if (cs_sync) begin
          frame_err_d = (cnt_q != '0);
          state_d     = S_IDLE;
          cnt_d       = '0;
          sr_d        = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      sr_q           <= '0;
      status_q       <= '0;
      addr_q         <= '0;
      wdata_q        <= '0;
      status_ready_q <= 1'b0;
      data_ready_q   <= 1'b0;
      frame_err_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      sr_q           <= sr_d;
      status_q       <= status_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      status_ready_q <= status_ready_d;
      data_ready_q   <= data_ready_d;
      frame_err_q    <= frame_err_d;
    end
  end

  assign status        = status_q;
  assign addr          = addr_q;
  assign wdata         = wdata_q;
  assign status_ready  = status_ready_q;
  assign address_ready = status_ready_q;
  assign data_ready    = data_ready_q;
  assign frame_err     = frame_err_q;
  assign cs_n_o        = cs_sync;

endmodule

// File: tb/tb_spi_rx_deframer.sv
// Directed bench for spi_rx_deframer: drives mode-0 SPI frames and checks the
// decoded header, data words, strobes, frame errors and strobe latency.
module tb_spi_rx_deframer;

  localparam int SYNC_STAGES = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        sclk;
  logic        mosi;
  logic        cs_n;
  logic [3:0]  status;
  logic [19:0] addr;
  logic [15:0] wdata;
  logic        status_ready;
  logic        address_ready;
  logic        data_ready;
  logic        cs_n_o;
  logic        frame_err;

  int check_total = 0;
  int pass_count  = 0;

  int          hdr_cnt = 0;
  int          word_cnt = 0;
  int          err_cnt = 0;
  logic [3:0]  last_status = '0;
  logic [19:0] last_addr = '0;
  logic [15:0] word_log[$];

  spi_rx_deframer #(.SYNC_STAGES(SYNC_STAGES)) dut (
    .clk(clk), .reset_n(reset_n), .sclk(sclk), .mosi(mosi), .cs_n(cs_n),
    .status(status), .addr(addr), .wdata(wdata),
    .status_ready(status_ready), .address_ready(address_ready),
    .data_ready(data_ready), .cs_n_o(cs_n_o), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_total++;
    if (got === exp) pass_count++;
    else $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic waitCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic sendBits(input logic [31:0] val, input int n, input int half);
    for (int i = n - 1; i >= 0; i--) begin
      mosi = val[i];
      waitCycles(half);
      sclk = 1'b1;
      waitCycles(half);
      sclk = 1'b0;
    end
  endtask

  task automatic applyStimulus(input logic [3:0] st, input logic [19:0] ad, input int nwords,
                               input logic [63:0] data, input int tailbits, input int half);
    cs_n = 1'b0;
    waitCycles(6);
    sendBits({8'h00, st, ad}, 24, half);
    for (int k = 0; k < nwords; k++) sendBits({16'h0000, data[63-16*k -: 16]}, 16, half);
    if (tailbits > 0) sendBits(32'h0000_5555, tailbits, half);
    waitCycles(2);
    cs_n = 1'b1;
    waitCycles(8);
  endtask

  // Strobe monitor, sampled on the falling edge away from the update edge.
  always @(negedge clk) begin
    if (status_ready || address_ready) begin
      checkOutput("status_ready", {31'b0, status_ready}, 32'd1);
      checkOutput("address_ready", {31'b0, address_ready}, 32'd1);
      hdr_cnt++;
      last_status = status;
      last_addr   = addr;
    end
    if (data_ready) begin
      checkOutput("no_overlap", {31'b0, status_ready}, 32'd0);
      word_cnt++;
      word_log.push_back(wdata);
    end
    if (frame_err) err_cnt++;
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int h0, w0, e0, lat;

    reset_n = 1'b0;
    sclk    = 1'b0;
    mosi    = 1'b0;
    cs_n    = 1'b1;
    waitCycles(3);
    checkOutput("rst_status", {28'b0, status}, 32'h0);
    checkOutput("rst_addr", {12'b0, addr}, 32'h0);
    checkOutput("rst_wdata", {16'b0, wdata}, 32'h0);
    checkOutput("rst_cs_n_o", {31'b0, cs_n_o}, 32'd1);
    checkOutput("rst_strobes", {29'b0, status_ready, data_ready, frame_err}, 32'h0);
    reset_n = 1'b1;
    waitCycles(4);

    // Write frame with one data word
    h0 = hdr_cnt; w0 = word_cnt; e0 = err_cnt;
    applyStimulus(4'b0100, 20'h12344, 1, {16'hBEEF, 48'h0}, 0, 4);
    checkOutput("t1_hdr_cnt", hdr_cnt - h0, 32'd1);
    checkOutput("t1_status", {28'b0, last_status}, 32'h4);
    checkOutput("t1_addr", {12'b0, last_addr}, 32'h12344);
    checkOutput("t1_word_cnt", word_cnt - w0, 32'd1);
    checkOutput("t1_wdata", {16'b0, word_log[w0]}, 32'hBEEF);
    checkOutput("t1_err", err_cnt - e0, 32'd0);

    // Burst of three words
    h0 = hdr_cnt; w0 = word_cnt; e0 = err_cnt;
    applyStimulus(4'b0110, 20'h00010, 3, {16'h1111, 16'h2222, 16'h3333, 16'h0}, 0, 4);
    checkOutput("t2_hdr_cnt", hdr_cnt - h0, 32'd1);
    checkOutput("t2_status", {28'b0, last_status}, 32'h6);
    checkOutput("t2_addr", {12'b0, last_addr}, 32'h00010);
    checkOutput("t2_word_cnt", word_cnt - w0, 32'd3);
    for (int k = 0; k < 3; k++)
      if (word_cnt - w0 > k) checkOutput($sformatf("t2_word%0d", k), {16'b0, word_log[w0+k]}, 32'h1111 * (k + 1));
    checkOutput("t2_err", err_cnt - e0, 32'd0);
    checkOutput("t2_cs_n_o", {31'b0, cs_n_o}, 32'd1);

    // Abort after ten header bits
    h0 = hdr_cnt; w0 = word_cnt; e0 = err_cnt;
    cs_n = 1'b0;
    waitCycles(6);
    sendBits(32'h0000_02F5, 10, 4);
    waitCycles(2);
    checkOutput("t3_cs_n_o_low", {31'b0, cs_n_o}, 32'd0);
    cs_n = 1'b1;
    waitCycles(8);
    checkOutput("t3_err", err_cnt - e0, 32'd1);
    checkOutput("t3_no_hdr", hdr_cnt - h0, 32'd0);
    checkOutput("t3_no_word", word_cnt - w0, 32'd0);
    checkOutput("t3_status_held", {28'b0, status}, 32'h6);
    checkOutput("t3_addr_held", {12'b0, addr}, 32'h00010);
    checkOutput("t3_cs_n_o", {31'b0, cs_n_o}, 32'd1);

    // Read frame with a dummy word and a 7-bit partial word
    h0 = hdr_cnt; w0 = word_cnt; e0 = err_cnt;
    applyStimulus(4'b0001, 20'hFFFFE, 1, {16'hA5A5, 48'h0}, 7, 4);
    checkOutput("t4_hdr_cnt", hdr_cnt - h0, 32'd1);
    checkOutput("t4_status", {28'b0, last_status}, 32'h1);
    checkOutput("t4_addr", {12'b0, last_addr}, 32'hFFFFE);
    checkOutput("t4_word_cnt", word_cnt - w0, 32'd1);
    checkOutput("t4_err", err_cnt - e0, 32'd1);
    checkOutput("t4_wdata_held", {16'b0, wdata}, 32'hA5A5);

    // Asynchronous reset in the middle of a data word
    cs_n = 1'b0;
    waitCycles(6);
    sendBits({8'h00, 4'b0100, 20'h0ABCD}, 24, 4);
    sendBits(32'h0000_00C3, 8, 4);
    reset_n = 1'b0;
    #1;
    checkOutput("t5_status", {28'b0, status}, 32'h0);
    checkOutput("t5_addr", {12'b0, addr}, 32'h0);
    checkOutput("t5_wdata", {16'b0, wdata}, 32'h0);
    checkOutput("t5_cs_n_o", {31'b0, cs_n_o}, 32'd1);
    checkOutput("t5_strobes", {29'b0, status_ready, data_ready, frame_err}, 32'h0);
    cs_n = 1'b1;
    waitCycles(3);
    reset_n = 1'b1;
    waitCycles(4);
    h0 = hdr_cnt; w0 = word_cnt; e0 = err_cnt;
    applyStimulus(4'b0100, 20'h54321, 1, {16'h1234, 48'h0}, 0, 4);
    checkOutput("t5_hdr_cnt", hdr_cnt - h0, 32'd1);
    checkOutput("t5_status_new", {28'b0, last_status}, 32'h4);
    checkOutput("t5_addr_new", {12'b0, last_addr}, 32'h54321);
    checkOutput("t5_word_cnt", word_cnt - w0, 32'd1);
    checkOutput("t5_wdata_new", {16'b0, wdata}, 32'h1234);
    checkOutput("t5_err", err_cnt - e0, 32'd0);

    // clk = 4x sclk, cs_n rises together with the last sclk edge
    h0 = hdr_cnt; w0 = word_cnt; e0 = err_cnt;
    cs_n = 1'b0;
    waitCycles(6);
    sendBits({8'h00, 4'b0110, 20'h0F0F0}, 24, 2);
    sendBits(32'h0000_61E1, 15, 2);
    mosi = 1'b1;
    waitCycles(2);
    sclk = 1'b1;
    cs_n = 1'b1;
    lat = -1;
    for (int c = 1; c <= 20 && lat < 0; c++) begin
      @(posedge clk);
      #1;
      if (data_ready) lat = c;
      if (c == 2) sclk = 1'b0;
    end
    sclk = 1'b0;
    waitCycles(8);
    checkOutput("t6_latency", lat, SYNC_STAGES + 2);
    checkOutput("t6_hdr_cnt", hdr_cnt - h0, 32'd1);
    checkOutput("t6_addr", {12'b0, last_addr}, 32'h0F0F0);
    checkOutput("t6_word_cnt", word_cnt - w0, 32'd1);
    checkOutput("t6_wdata", {16'b0, wdata}, 32'hC3C3);
    checkOutput("t6_err", err_cnt - e0, 32'd0);
    checkOutput("t6_cs_n_o", {31'b0, cs_n_o}, 32'd1);

    $display("%0d/%0d checks passed", pass_count, check_total);
    $finish;
  end

endmodule
